serial_adder: RTL and testbench

//   Bit-serial, LSB-first adder: the addition counterpart to our full-subtractor datapath.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units (adder and subtractor).
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to index `value` items; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop resolve one bit per clock.
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             cell_s, cell_cout;

  full_adder_cell u_cell (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        acc_d   = {cell_s, acc_q[WIDTH-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = {cell_s, acc_q[WIDTH-1:1]};
          cout_d  = cell_cout;
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ cell_cout;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          op_a_d  = a;
          op_b_d  = b;
          carry_d = carryIn;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign ready    = (state_q != ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign carryOut = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic       clk, rst, start, carryIn;
  logic [7:0] a, b;
  logic       ready, busy, done, carryOut, overflow;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryIn  (carryIn),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carryOut),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, then count rising edges until done is seen (bounded).
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat);
    @(negedge clk);
    a = av; b = bv; carryIn = cv; start = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat;
    int pulses;
    int last_pulse;
    int gap;
    logic [7:0] seen_sum;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; carryIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", 32'(sum), 0);
    check("reset_cout", 32'(carryOut), 0);
    check("reset_ovf", 32'(overflow), 0);
    check("reset_done", 32'(done), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ready", 32'(ready), 1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 9);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(carryOut), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      if (i == 0) begin
        check("done_ready", 32'(ready), 1);
        check("done_busy", 32'(busy), 0);
      end
    end

    // Reset four cycles into 0x12+0x34: abandon, clear outputs, no done pulse.
    @(negedge clk);
    a = 8'h12; b = 8'h34; carryIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midop_busy", 32'(busy), 1);
    check("midop_ready", 32'(ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_sum", 32'(sum), 0);
    check("rst_mid_cout", 32'(carryOut), 0);
    check("rst_mid_ovf", 32'(overflow), 0);
    check("rst_mid_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_mid_no_done", 32'(pulses), 0);
    run_op(8'h12, 8'h34, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 9);
    check("post_rst_sum", 32'(sum), 32'h46);

    // start pulsed while busy must be ignored.
    @(negedge clk);
    a = 8'h01; b = 8'h01; carryIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'h0F; carryIn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    seen_sum = 8'hXX;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        seen_sum = sum;
      end
    end
    check("ignore_pulses", 32'(pulses), 1);
    check("ignore_sum", 32'(seen_sum), 32'h02);
    check("ignore_cout", 32'(carryOut), 0);

    // Start held high: two back-to-back ops, results 9 cycles apart.
    @(negedge clk);
    a = 8'h10; b = 8'h20; carryIn = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h05; b = 8'h06;
    pulses = 0;
    last_pulse = 0;
    gap = 0;
    for (int i = 1; i < 30 && pulses < 2; i++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b_first_sum", 32'(sum), 32'h30);
        end else begin
          gap = i - last_pulse;
          start = 1'b0;
          check("b2b_second_sum", 32'(sum), 32'h0B);
        end
        last_pulse = i;
      end
      if (pulses < 2) @(negedge clk);
    end
    start = 1'b0;
    check("b2b_pulses", 32'(pulses), 2);
    check("b2b_gap", 32'(gap), 9);
    repeat (2) @(negedge clk);
    check("b2b_idle_ready", 32'(ready), 1);
    check("b2b_idle_done", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
